// File: rtl/trace_pkg.sv
// Shared types for the trace replay/capture blocks.
package trace_pkg;

  localparam int unsigned TRACE_WIDTH = 3;
  localparam int unsigned TRACE_TW    = 16;

  // One value-change record as it travels through the record FIFO.
  typedef struct packed {
    logic [TRACE_TW-1:0]    delta;
    logic [TRACE_WIDTH-1:0] value;
  } trace_rec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } trace_state_e;

  // A zero delta still costs one cycle, so replayed changes never collapse.
  function automatic logic [TRACE_TW-1:0] eff_delta(input logic [TRACE_TW-1:0] d);
    return (d == '0) ? TRACE_TW'(1) : d;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; power-of-two depth, no full-and-pop passthrough.
module trace_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/trace_replay.sv
// Replays {delta, value} records onto a bus, counting each delta in cycles.
module trace_replay
  import trace_pkg::*;
#(
  parameter int unsigned WIDTH = TRACE_WIDTH,
  parameter int unsigned TW    = TRACE_TW,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TW-1:0]    in_delta,
  input  logic [WIDTH-1:0] in_value,
  input  logic             pause,
  output logic [WIDTH-1:0] out_value,
  output logic             out_strobe,
  output logic             out_changed,
  output logic             busy,
  output logic [31:0]      stime
);

  localparam int unsigned STIME_W = 32;

  trace_state_e     state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_value_q, cur_value_d;
  logic [WIDTH-1:0] out_value_q, out_value_d;
  logic             out_strobe_q, out_strobe_d;
  logic             out_changed_q, out_changed_d;
  logic [STIME_W-1:0] stime_q, stime_d;

  trace_rec_t push_rec;
  trace_rec_t head_rec;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;

  assign push_rec.delta = TRACE_TW'(in_delta);
  assign push_rec.value = TRACE_WIDTH'(in_value);
  assign in_ready       = ~fifo_full;
  assign fifo_push      = in_valid & ~fifo_full;

  trace_fifo #(
    .DW    ($bits(trace_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (push_rec),
    .pop_i   (fifo_pop),
    .data_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Holding-register control: load from FIFO, count down, apply and chain.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_value_d   = cur_value_q;
    out_value_d   = out_value_q;
    out_strobe_d  = 1'b0;
    out_changed_d = 1'b0;
    fifo_pop      = 1'b0;
    stime_d       = stime_q + STIME_W'(1);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          cnt_d       = TW'(eff_delta(head_rec.delta));
          cur_value_d = WIDTH'(head_rec.value);
          state_d     = COUNT;
        end
      end
      COUNT: begin
        if (!pause) begin
          if (cnt_q > TW'(1)) begin
            cnt_d = cnt_q - TW'(1);
          end else begin
            out_value_d   = cur_value_q;
            out_strobe_d  = 1'b1;
            out_changed_d = (cur_value_q != out_value_q);
            if (!fifo_empty) begin
              fifo_pop    = 1'b1;
              cnt_d       = TW'(eff_delta(head_rec.delta));
              cur_value_d = WIDTH'(head_rec.value);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, countdown, output and timestamp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cur_value_q   <= '0;
      out_value_q   <= '0;
      out_strobe_q  <= 1'b0;
      out_changed_q <= 1'b0;
      stime_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_value_q   <= cur_value_d;
      out_value_q   <= out_value_d;
      out_strobe_q  <= out_strobe_d;
      out_changed_q <= out_changed_d;
      stime_q       <= stime_d;
    end
  end

  assign out_value   = out_value_q;
  assign out_strobe  = out_strobe_q;
  assign out_changed = out_changed_q;
  assign stime       = stime_q;
  assign busy        = (state_q == COUNT) | ~fifo_empty;

endmodule

// File: tb/tb_trace_replay.sv
// Bench for trace_replay: directed tables/sequences plus random traffic vs a schedule model.
module tb_trace_replay;

  localparam int unsigned W     = 3;
  localparam int unsigned TW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic          pause    = 1'b0;
  logic [TW-1:0] in_delta = '0;
  logic [W-1:0]  in_value = '0;
  logic          in_ready;
  logic [W-1:0]  out_value;
  logic          out_strobe;
  logic          out_changed;
  logic          busy;
  logic [31:0]   stime;

  trace_replay #(.WIDTH(W), .TW(TW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_delta    (in_delta),
    .in_value    (in_value),
    .pause       (pause),
    .out_value   (out_value),
    .out_strobe  (out_strobe),
    .out_changed (out_changed),
    .busy        (busy),
    .stime       (stime)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: absolute apply deadlines ----------------
  typedef struct packed {
    logic [TW-1:0] d;
    logic [W-1:0]  v;
  } rec_t;

  rec_t        m_q[$];
  rec_t        m_rec;
  rec_t        m_new;
  bit          m_cur = 1'b0;
  longint      m_t   = 0;
  longint      m_due = 0;
  logic [W-1:0] m_out = '0;
  logic        m_strobe = 1'b0;
  logic        m_changed = 1'b0;
  logic [31:0] m_stime = '0;
  int          preload_cnt = 0;
  int          preload_seen = 0;
  bit          m_acc;

  function automatic longint eff(input logic [TW-1:0] d);
    return (d == 0) ? 64'd1 : longint'(d);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_cur = 1'b0; m_t = 0; m_due = 0;
      m_out = '0; m_strobe = 1'b0; m_changed = 1'b0; m_stime = '0;
    end else begin
      m_acc = in_valid && (m_q.size() < DEPTH);
      m_t++;
      if (preload_cnt != preload_seen) begin
        m_stime = 32'hFFFF_FFFE;
        preload_seen = preload_cnt;
      end
      m_stime = m_stime + 32'd1;
      m_strobe = 1'b0;
      m_changed = 1'b0;
      if (!m_cur) begin
        if (m_q.size() > 0) begin
          m_rec = m_q.pop_front();
          m_cur = 1'b1;
          m_due = m_t + eff(m_rec.d);
        end
      end else if (pause) begin
        m_due++;
      end else if (m_t == m_due) begin
        m_strobe  = 1'b1;
        m_changed = (m_rec.v != m_out);
        m_out     = m_rec.v;
        if (m_q.size() > 0) begin
          m_rec = m_q.pop_front();
          m_due = m_t + eff(m_rec.d);
        end else begin
          m_cur = 1'b0;
        end
      end
      if (m_acc) begin
        m_new.d = in_delta;
        m_new.v = in_value;
        m_q.push_back(m_new);
      end
    end
  end

  // ---------------- per-cycle checker and strobe log ----------------
  int           log_cyc[$];
  logic [W-1:0] log_val[$];
  logic         log_chg[$];

  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    check("model", 64'({out_value, out_strobe, out_changed, in_ready, busy, stime}),
          64'({m_out, m_strobe, m_changed, (m_q.size() < DEPTH), (m_cur || m_q.size() > 0), m_stime}));
    if (out_strobe) begin
      log_cyc.push_back(cyc);
      log_val.push_back(out_value);
      log_chg.push_back(out_changed);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers (entered and left at a negedge) ----------------
  task automatic push(input int d, input int v, output int acc_cyc);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_delta = TW'(d);
    in_value = W'(v);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("push_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobes(input int n);
    int guard;
    guard = 0;
    while (log_cyc.size() < n && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (log_cyc.size() < n) check("strobe_timeout", 64'(log_cyc.size()), 64'(n));
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_val.delete();
    log_chg.delete();
  endtask

  typedef struct {
    logic         v;
    int           d;
    int           val;
    logic         p;
    logic [W-1:0] eo;
    logic         es;
    logic         ec;
    logic         er;
    logic         eb;
  } vec_t;

  vec_t         tbl[8];
  logic [31:0]  wrap_exp[3];
  int           acc;
  int           acc2;
  logic         prev_ready;

  initial begin
    // Toggle replay table: each row is one edge, expectation sampled after it.
    tbl[0] = '{1'b1, 1, 1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1, 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1, 1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1, 0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1, 1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 0, 0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 0, 0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 0, 0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    wrap_exp[0] = 32'hFFFF_FFFF;
    wrap_exp[1] = 32'h0000_0000;
    wrap_exp[2] = 32'h0000_0001;

    // Reset then idle.
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({out_value, out_strobe, out_changed, in_ready, busy, stime}),
          64'({3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}));
    rst_n = 1'b1;
    clear_log();
    repeat (10) @(negedge clk);
    check("idle_stime", 64'(stime), 64'd10);
    check("idle_outs", 64'({out_value, in_ready, busy}), 64'({3'd0, 1'b1, 1'b0}));
    check("idle_strobes", 64'(log_cyc.size()), 64'd0);

    // Toggle table.
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].v;
      in_delta = TW'(tbl[i].d);
      in_value = W'(tbl[i].val);
      pause    = tbl[i].p;
      @(posedge clk);
      #2;
      check($sformatf("toggle_row%0d", i),
            64'({out_value, out_strobe, out_changed, in_ready, busy}),
            64'({tbl[i].eo, tbl[i].es, tbl[i].ec, tbl[i].er, tbl[i].eb}));
      @(negedge clk);
    end

    // Full FIFO with zero deltas, sink held by pause.
    clear_log();
    pause = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push(0, i, acc);
      if (i == 4) check("ready_after4", 64'(in_ready), 64'd1);
    end
    check("ready_after5", 64'(in_ready), 64'd0);
    in_value = 3'd6;
    in_delta = '0;
    repeat (3) begin
      @(negedge clk);
      check("full_hold_ready", 64'({in_ready, out_strobe}), 64'({1'b0, 1'b0}));
    end
    pause = 1'b0;
    push(0, 6, acc);
    idle(10);
    check("full_count", 64'(log_cyc.size()), 64'd6);
    for (int i = 0; i < log_cyc.size() && i < 6; i++) begin
      check($sformatf("full_val%0d", i), 64'(log_val[i]), 64'(i + 1));
      check($sformatf("full_gap%0d", i), 64'(log_cyc[i] - log_cyc[0]), 64'(i));
    end

    // Pause stretches the countdown; a repeated value strobes without change.
    clear_log();
    push(5, 3, acc);
    idle(2);
    pause = 1'b1;
    repeat (4) @(negedge clk);
    pause = 1'b0;
    wait_strobes(1);
    if (log_cyc.size() >= 1) begin
      check("pause_when", 64'(log_cyc[0]), 64'(acc + 10));
      check("pause_val", 64'({log_val[0], log_chg[0]}), 64'({3'd3, 1'b1}));
    end
    clear_log();
    push(2, 3, acc2);
    idle(1);
    wait_strobes(1);
    if (log_cyc.size() >= 1) begin
      check("same_when", 64'(log_cyc[0]), 64'(acc2 + 3));
      check("same_val", 64'({log_val[0], log_chg[0]}), 64'({3'd3, 1'b0}));
    end
    idle(3);

    // Reset mid-countdown loses the pending record.
    push(100, 7, acc);
    idle(49);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outs", 64'({out_value, out_strobe, out_changed, in_ready, busy, stime}),
          64'({3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}));
    rst_n = 1'b1;
    clear_log();
    idle(120);
    check("midrst_nostrobe", 64'({log_cyc.size(), out_value}), 64'({32'd0, 3'd0}));
    push(1, 7, acc);
    idle(1);
    wait_strobes(1);
    if (log_cyc.size() >= 1) begin
      check("postrst_when", 64'(log_cyc[0]), 64'(acc + 2));
      check("postrst_val", 64'({log_val[0], log_chg[0]}), 64'({3'd7, 1'b1}));
    end
    idle(3);

    // stime wrap through a forced preload.
    force dut.stime_q = 32'hFFFF_FFFE;
    preload_cnt++;
    #1;
    release dut.stime_q;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("stime_wrap%0d", i), 64'(stime), 64'(wrap_exp[i]));
    end
    @(negedge clk);

    // Random traffic against the model; offers held while not ready.
    prev_ready = in_ready;
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !prev_ready)) begin
        in_valid = ($urandom_range(0, 9) < 6);
        in_delta = ($urandom_range(0, 9) < 8) ? TW'($urandom_range(0, 3)) : TW'($urandom_range(4, 12));
        in_value = W'($urandom);
      end
      pause = ($urandom_range(0, 99) < 12);
      prev_ready = in_ready;
      @(negedge clk);
    end
    pause = 1'b0;
    idle(80);
    check("drain_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
